// File: rtl/side_info_2ch_packer.sv
// side_info_2ch_packer
//
// Packs one MPEG-1 Layer III stereo side-info field set (256 bits) and sends
// it MSB-first as 32 bytes with backpressure.
//
// Optional build macro: SIDE_INFO_FIELD_CHECK_EN
//   defined   : illegal field sets are consumed without transmission and
//               flagged by a one-cycle err pulse.
//   undefined : err is tied low; every field set is transmitted verbatim.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   fi_valid / fi_ready      field-set input handshake
//   main_data_begin ..
//   count1table_select       decoded side-info fields ([gr][ch], scfsi [ch][band])
//   axiod / axiov / axiir    output byte stream (data / valid / downstream ready)
//   axiolast                 high together with byte 31
//   err                      illegal field-set pulse
//
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high. A valid source keeps its data stable until that edge;
// ready may change freely. fi_valid is not looked at while a frame is being sent.

module side_info_2ch_packer (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fi_valid,
   output logic                    fi_ready,
   input  logic [8:0]              main_data_begin,
   input  logic [2:0]              private_bits,
   input  logic [1:0][3:0]         scfsi,
   input  logic [1:0][1:0][11:0]   part2_3_length,
   input  logic [1:0][1:0][8:0]    big_values,
   input  logic [1:0][1:0][7:0]    global_gain,
   input  logic [1:0][1:0][3:0]    scalefac_compress,
   input  logic [1:0][1:0]         window_switching_flag,
   input  logic [1:0][1:0][1:0]    block_type,
   input  logic [1:0][1:0]         mixed_block_flag,
   input  logic [1:0][1:0][4:0]    table_select_1,
   input  logic [1:0][1:0][4:0]    table_select_2,
   input  logic [1:0][1:0][4:0]    table_select_3,
   input  logic [1:0][1:0][2:0]    subblock_gain_1,
   input  logic [1:0][1:0][2:0]    subblock_gain_2,
   input  logic [1:0][1:0][2:0]    subblock_gain_3,
   input  logic [1:0][1:0][3:0]    region0_count,
   input  logic [1:0][1:0][2:0]    region1_count,
   input  logic [1:0][1:0]         preflag,
   input  logic [1:0][1:0]         scalefac_scale,
   input  logic [1:0][1:0]         count1table_select,
   output logic [7:0]              axiod,
   output logic                    axiov,
   input  logic                    axiir,
   output logic                    axiolast,
   output logic                    err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]            state;
   logic [255:0]          sreg;
   logic [4:0]            byte_cnt;
   logic [1:0][1:0][58:0] gc_bits;
   logic [255:0]          packed_word;
   logic                  accept;
   logic                  load;
   logic                  xfer;

   // 59-bit granule/channel block; the wsf bit selects which optional fields
   // are carried, unused fields of the other branch are simply dropped.
   always_comb begin
      gc_bits = '0;
      for (int g = 0; g < 2; g++) begin
         for (int c = 0; c < 2; c++) begin
            if (window_switching_flag[g][c]) begin
               gc_bits[g][c] = {part2_3_length[g][c], big_values[g][c],
                                global_gain[g][c], scalefac_compress[g][c], 1'b1,
                                block_type[g][c], mixed_block_flag[g][c],
                                table_select_1[g][c], table_select_2[g][c],
                                subblock_gain_1[g][c], subblock_gain_2[g][c],
                                subblock_gain_3[g][c],
                                preflag[g][c], scalefac_scale[g][c],
                                count1table_select[g][c]};
            end else begin
               gc_bits[g][c] = {part2_3_length[g][c], big_values[g][c],
                                global_gain[g][c], scalefac_compress[g][c], 1'b0,
                                table_select_1[g][c], table_select_2[g][c],
                                table_select_3[g][c],
                                region0_count[g][c], region1_count[g][c],
                                preflag[g][c], scalefac_scale[g][c],
                                count1table_select[g][c]};
            end
         end
      end
   end

   // Bit 255 goes out first: header (20 bits) then gr0ch0, gr0ch1, gr1ch0, gr1ch1.
   assign packed_word = {main_data_begin, private_bits,
                         scfsi[0][0], scfsi[0][1], scfsi[0][2], scfsi[0][3],
                         scfsi[1][0], scfsi[1][1], scfsi[1][2], scfsi[1][3],
                         gc_bits[0][0], gc_bits[0][1], gc_bits[1][0], gc_bits[1][1]};

   assign fi_ready = (state == ST_IDLE);
   assign accept   = fi_valid && fi_ready;
   assign xfer     = axiov && axiir;

   // The output byte is the top of the shift register, so it is registered
   // and holds automatically during a stall. After 32 shifts the register is
   // all zeros, which leaves axiod at 0 between frames.
   assign axiod = sreg[255:248];

`ifdef SIDE_INFO_FIELD_CHECK_EN
   logic illegal;

   always_comb begin
      illegal = 1'b0;
      for (int g = 0; g < 2; g++) begin
         for (int c = 0; c < 2; c++) begin
            if ((window_switching_flag[g][c] && (block_type[g][c] == 2'd0)) ||
                (big_values[g][c] > 9'd288)) begin
               illegal = 1'b1;
            end
         end
      end
   end

   assign load = accept && !illegal;

   always_ff @(posedge clk) begin
      if (!rst) begin
         err <= 1'b0;
      end else begin
         err <= accept && illegal;
      end
   end
`else
   assign load = accept;
   assign err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_IDLE;
         sreg     <= '0;
         byte_cnt <= '0;
         axiov    <= 1'b0;
         axiolast <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  sreg     <= packed_word;
                  byte_cnt <= 5'd0;
                  axiov    <= 1'b1;
                  axiolast <= 1'b0;
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  sreg     <= {sreg[247:0], 8'h00};
                  byte_cnt <= byte_cnt + 5'd1;
                  // The byte about to be presented is byte 31.
                  axiolast <= (byte_cnt == 5'd30);
                  if (byte_cnt == 5'd31) begin
                     axiov    <= 1'b0;
                     axiolast <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_side_info_2ch_packer.sv
// Directed bench for side_info_2ch_packer: reset, packing patterns, stall,
// back-to-back frames, mid-frame reset and (when built with
// SIDE_INFO_FIELD_CHECK_EN) illegal field-set rejection.

module tb_side_info_2ch_packer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic                    fi_valid;
   logic                    fi_ready;
   logic [8:0]              main_data_begin;
   logic [2:0]              private_bits;
   logic [1:0][3:0]         scfsi;
   logic [1:0][1:0][11:0]   part2_3_length;
   logic [1:0][1:0][8:0]    big_values;
   logic [1:0][1:0][7:0]    global_gain;
   logic [1:0][1:0][3:0]    scalefac_compress;
   logic [1:0][1:0]         window_switching_flag;
   logic [1:0][1:0][1:0]    block_type;
   logic [1:0][1:0]         mixed_block_flag;
   logic [1:0][1:0][4:0]    table_select_1;
   logic [1:0][1:0][4:0]    table_select_2;
   logic [1:0][1:0][4:0]    table_select_3;
   logic [1:0][1:0][2:0]    subblock_gain_1;
   logic [1:0][1:0][2:0]    subblock_gain_2;
   logic [1:0][1:0][2:0]    subblock_gain_3;
   logic [1:0][1:0][3:0]    region0_count;
   logic [1:0][1:0][2:0]    region1_count;
   logic [1:0][1:0]         preflag;
   logic [1:0][1:0]         scalefac_scale;
   logic [1:0][1:0]         count1table_select;
   logic [7:0]              axiod;
   logic                    axiov;
   logic                    axiir;
   logic                    axiolast;
   logic                    err;

   side_info_2ch_packer dut (
      .clk                   (clk),
      .rst                   (rst),
      .fi_valid              (fi_valid),
      .fi_ready              (fi_ready),
      .main_data_begin       (main_data_begin),
      .private_bits          (private_bits),
      .scfsi                 (scfsi),
      .part2_3_length        (part2_3_length),
      .big_values            (big_values),
      .global_gain           (global_gain),
      .scalefac_compress     (scalefac_compress),
      .window_switching_flag (window_switching_flag),
      .block_type            (block_type),
      .mixed_block_flag      (mixed_block_flag),
      .table_select_1        (table_select_1),
      .table_select_2        (table_select_2),
      .table_select_3        (table_select_3),
      .subblock_gain_1       (subblock_gain_1),
      .subblock_gain_2       (subblock_gain_2),
      .subblock_gain_3       (subblock_gain_3),
      .region0_count         (region0_count),
      .region1_count         (region1_count),
      .preflag               (preflag),
      .scalefac_scale        (scalefac_scale),
      .count1table_select    (count1table_select),
      .axiod                 (axiod),
      .axiov                 (axiov),
      .axiir                 (axiir),
      .axiolast              (axiolast),
      .err                   (err)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_d [32];
   logic       rx_l [32];
   int         rx_w [32];
   int         rx_c [32];

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fields;
      main_data_begin       = '0;
      private_bits          = '0;
      scfsi                 = '0;
      part2_3_length        = '0;
      big_values            = '0;
      global_gain           = '0;
      scalefac_compress     = '0;
      window_switching_flag = '0;
      block_type            = '0;
      mixed_block_flag      = '0;
      table_select_1        = '0;
      table_select_2        = '0;
      table_select_3        = '0;
      subblock_gain_1       = '0;
      subblock_gain_2       = '0;
      subblock_gain_3       = '0;
      region0_count         = '0;
      region1_count         = '0;
      preflag               = '0;
      scalefac_scale        = '0;
      count1table_select    = '0;
   endtask

   // Pattern 0: main_data_begin all ones.
   // Pattern 1: gr0ch0 window switching, block_type 2, ts1 1F, sbg 7/0/7.
   // Pattern 2: private_bits 5, scfsi ch1 band3, gr0ch0 global_gain A5,
   //            gr1ch1 count1table_select (the very last bit).
   task automatic set_pattern(input int p);
      clear_fields();
      case (p)
         0: main_data_begin = 9'h1FF;
         1: begin
            window_switching_flag[0][0] = 1'b1;
            block_type[0][0]            = 2'd2;
            table_select_1[0][0]        = 5'h1F;
            subblock_gain_1[0][0]       = 3'd7;
            subblock_gain_3[0][0]       = 3'd7;
         end
         default: begin
            private_bits             = 3'b101;
            scfsi[1][3]              = 1'b1;
            global_gain[0][0]        = 8'hA5;
            count1table_select[1][1] = 1'b1;
         end
      endcase
   endtask

   // Hand-computed byte images of the patterns above.
   task automatic fill_expected(input int p);
      exp_q.delete();
      for (int k = 0; k < 32; k++) exp_q.push_back(8'h00);
      case (p)
         0: begin
            exp_q[0] = 8'hFF;
            exp_q[1] = 8'h80;
         end
         1: begin
            exp_q[6] = 8'h06;
            exp_q[7] = 8'h7C;
            exp_q[8] = 8'h1C;
            exp_q[9] = 8'h70;
         end
         default: begin
            exp_q[1]  = 8'h50;
            exp_q[2]  = 8'h10;
            exp_q[5]  = 8'h52;
            exp_q[6]  = 8'h80;
            exp_q[31] = 8'h01;
         end
      endcase
   endtask

   // Raise fi_valid and wait for the accepting edge; returns #1 after it.
   task automatic handshake(input bit keep, output logic ok);
      ok = 1'b0;
      fi_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (fi_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!keep) fi_valid = 1'b0;
   endtask

   // Wait (bounded) for one byte transfer; returns #1 after the transfer edge.
   task automatic get_byte(output logic [7:0] d, output logic l, output int waited,
                           output int at_cyc, output logic ok);
      ok = 1'b0; d = '0; l = 1'b0; waited = 0; at_cyc = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (axiov === 1'b1 && axiir === 1'b1) begin
            d = axiod; l = axiolast; at_cyc = cyc; ok = 1'b1;
            break;
         end
         waited++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic recv_bytes(input int first, input int last, output logic ok);
      logic [7:0] d;
      logic l;
      int w;
      int c;
      logic o;
      ok = 1'b1;
      for (int k = first; k <= last; k++) begin
         get_byte(d, l, w, c, o);
         rx_d[k] = d; rx_l[k] = l; rx_w[k] = w; rx_c[k] = c;
         if (!o) begin
            ok = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL reset_axiov got %b exp 0", axiov); end
      checks++; if (axiolast !== 1'b0) begin errors++; $display("FAIL reset_axiolast got %b exp 0", axiolast); end
      checks++; if (axiod !== 8'h00) begin errors++; $display("FAIL reset_axiod got %h exp 00", axiod); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (fi_ready !== 1'b1) begin errors++; $display("FAIL reset_fi_ready got %b exp 1", fi_ready); end
      tick();
   endtask

   task automatic test_single_bit;
      logic ok;
      set_pattern(0); fill_expected(0); axiir = 1'b1;
      handshake(1'b0, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_accept got %b exp 1", ok); end
      recv_bytes(0, 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %b exp 1", ok); end
      checks++; if (rx_w[0] !== 0) begin errors++; $display("FAIL single_latency got %0d exp 0", rx_w[0]); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL single_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
         checks++;
         if (rx_l[k] !== (k == 31)) begin errors++; $display("FAIL single_last %0d got %b exp %b", k, rx_l[k], (k == 31)); end
      end
      @(negedge clk);
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL single_end_axiov got %b exp 0", axiov); end
      checks++; if (fi_ready !== 1'b1) begin errors++; $display("FAIL single_end_ready got %b exp 1", fi_ready); end
      tick();
   endtask

   task automatic test_window_switch;
      logic ok;
      set_pattern(1); fill_expected(1); axiir = 1'b1;
      handshake(1'b0, ok);
      recv_bytes(0, 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ws_timeout got %b exp 1", ok); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL ws_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
      end
      tick();
   endtask

   task automatic test_backpressure;
      logic ok;
      logic ok2;
      set_pattern(2); fill_expected(2); axiir = 1'b1;
      handshake(1'b0, ok);
      recv_bytes(0, 4, ok);
      axiir = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         checks++; if (axiov !== 1'b1) begin errors++; $display("FAIL bp_stall_axiov %0d got %b exp 1", s, axiov); end
         checks++; if (axiod !== 8'h52) begin errors++; $display("FAIL bp_stall_axiod %0d got %h exp 52", s, axiod); end
         checks++; if (axiolast !== 1'b0) begin errors++; $display("FAIL bp_stall_last %0d got %b exp 0", s, axiolast); end
         tick();
      end
      axiir = 1'b1;
      recv_bytes(5, 31, ok2);
      checks++; if ((ok && ok2) !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b exp 1", ok && ok2); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL bp_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
         checks++;
         if (rx_l[k] !== (k == 31)) begin errors++; $display("FAIL bp_last %0d got %b exp %b", k, rx_l[k], (k == 31)); end
      end
      @(negedge clk);
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL bp_extra_byte got %b exp 0", axiov); end
      tick();
   endtask

   task automatic test_back_to_back;
      logic ok;
      int a0;
      set_pattern(0); fill_expected(0); axiir = 1'b1;
      handshake(1'b1, ok);
      set_pattern(2);   // fi_valid stays high with the second field set
      recv_bytes(0, 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_a_timeout got %b exp 1", ok); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_a_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
      end
      a0 = rx_c[0];
      @(negedge clk);
      checks++; if (fi_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_last got %b exp 1", fi_ready); end
      @(posedge clk);
      #1;
      fi_valid = 1'b0;
      fill_expected(2);
      recv_bytes(0, 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_b_timeout got %b exp 1", ok); end
      checks++; if (rx_c[0] - a0 !== 33) begin errors++; $display("FAIL b2b_period got %0d exp 33", rx_c[0] - a0); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_b_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
      end
      @(negedge clk);
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL b2b_no_third got %b exp 0", axiov); end
      tick();
   endtask

   task automatic test_reset_mid_frame;
      logic ok;
      set_pattern(1); fill_expected(1); axiir = 1'b1;
      handshake(1'b0, ok);
      recv_bytes(0, 9, ok);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL rmid_pre_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL rmid_axiov got %b exp 0", axiov); end
      checks++; if (axiod !== 8'h00) begin errors++; $display("FAIL rmid_axiod got %h exp 00", axiod); end
      checks++; if (fi_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", fi_ready); end
      tick();
      set_pattern(2); fill_expected(2);
      handshake(1'b0, ok);
      recv_bytes(0, 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_timeout got %b exp 1", ok); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL rmid_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
         checks++;
         if (rx_l[k] !== (k == 31)) begin errors++; $display("FAIL rmid_last %0d got %b exp %b", k, rx_l[k], (k == 31)); end
      end
      tick();
   endtask

`ifdef SIDE_INFO_FIELD_CHECK_EN
   task automatic test_field_check;
      logic ok;
      axiir = 1'b1;
      // wsf = 1 with block_type 0, then a legal set on the very next cycle
      clear_fields();
      window_switching_flag[1][0] = 1'b1;
      handshake(1'b1, ok);
      set_pattern(0); fill_expected(0);
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL fc_wsf_err got %b exp 1", err); end
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL fc_wsf_axiov got %b exp 0", axiov); end
      checks++; if (fi_ready !== 1'b1) begin errors++; $display("FAIL fc_wsf_ready got %b exp 1", fi_ready); end
      @(posedge clk);
      #1;
      fi_valid = 1'b0;
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL fc_err_width got %b exp 0", err); end
      recv_bytes(0, 31, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fc_legal_timeout got %b exp 1", ok); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (rx_d[k] !== exp_q[k]) begin errors++; $display("FAIL fc_legal_byte %0d got %h exp %h", k, rx_d[k], exp_q[k]); end
      end
      tick();
      // big_values just over the limit
      clear_fields();
      big_values[0][1] = 9'd289;
      handshake(1'b0, ok);
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL fc_bv_err got %b exp 1", err); end
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL fc_bv_axiov got %b exp 0", axiov); end
      tick();
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL fc_bv_err_clear got %b exp 0", err); end
      checks++; if (axiov !== 1'b0) begin errors++; $display("FAIL fc_bv_no_send got %b exp 0", axiov); end
      tick();
   endtask
`endif

   // ---------------- sequence / report ----------------
   initial begin
      fi_valid = 1'b0;
      axiir    = 1'b0;
      clear_fields();
      test_reset();
      test_single_bit();
      test_window_switch();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef SIDE_INFO_FIELD_CHECK_EN
      test_field_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/side_info_2ch_packer.md
# side_info_2ch_packer

Serializer for MPEG-1 Layer III stereo side information: the transmit-side counterpart of the 2-channel side-info parser. Accepts one fully decoded side-info field set via a valid/ready handshake, packs it into the 256-bit (32-byte) bitstream layout and emits it MSB-first as a byte stream with backpressure. It sits in the encoder/test-vector path, between field generation and the frame assembler that follows the 4-byte header.

## Interface
Parameters: none.

Ports (all field arrays indexed `[gr][ch]` unless noted):
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset (`rst == 0` resets).
- `fi_valid`  in  1  field set valid.
- `fi_ready`  out  1  block can accept a field set.
- `main_data_begin`  in  9
- `private_bits`  in  3
- `scfsi`  in  [1:0][3:0]  indexed `[ch][band]`.
- `part2_3_length`  in  [1:0][1:0][11:0]
- `big_values`  in  [1:0][1:0][8:0]
- `global_gain`  in  [1:0][1:0][7:0]
- `scalefac_compress`  in  [1:0][1:0][3:0]
- `window_switching_flag`  in  [1:0][1:0]
- `block_type`  in  [1:0][1:0][1:0]
- `mixed_block_flag`  in  [1:0][1:0]
- `table_select_1`, `table_select_2`, `table_select_3`  in  [1:0][1:0][4:0]
- `subblock_gain_1`, `subblock_gain_2`, `subblock_gain_3`  in  [1:0][1:0][2:0]
- `region0_count`  in  [1:0][1:0][3:0]
- `region1_count`  in  [1:0][1:0][2:0]
- `preflag`, `scalefac_scale`, `count1table_select`  in  [1:0][1:0]
- `axiod`  out  8  output byte.
- `axiov`  out  1  output byte valid.
- `axiir`  in  1  downstream ready.
- `axiolast`  out  1  high with byte 31.
- `err`  out  1  one-cycle illegal-field pulse (see Configuration).

## Operation
- **States.**
  - IDLE: `fi_ready = 1`. `fi_valid` → latch the packed 256-bit word into the shift register, `byte_cnt = 0`, go to SEND.
  - SEND: `fi_ready = 0`. `fi_valid` is ignored.
- **Packing.** Bit 255 is the first bit on the wire.
  - Header part, in order: `main_data_begin`(9), `private_bits`(3), `scfsi` ch0 band0..3, then ch1 band0..3.
  - Then for gr0 ch0, gr0 ch1, gr1 ch0, gr1 ch1, 59 bits each:
    - `part2_3_length`(12), `big_values`(9), `global_gain`(8), `scalefac_compress`(4), `window_switching_flag`(1).
    - If `wsf = 1`: `block_type`(2), `mixed_block_flag`(1), `table_select_1`, `table_select_2`(5 each), `subblock_gain_1..3`(3 each).
    - If `wsf = 0`: `table_select_1..3`(5 each), `region0_count`(4), `region1_count`(3).
    - Both cases end with `preflag`, `scalefac_scale`, `count1table_select`.
  - Total: 20 + 4×59 = 256 bits exactly.
  - Fields unused by the selected branch are not transmitted.
- **Output byte.** Byte k = bits [255−8k : 248−8k].
- **Transfer.** A byte transfers when `axiov && axiir`. On transfer the register shifts left 8 and `byte_cnt` increments.
  - Transfer with `byte_cnt == 31`: clear `axiov`, return to IDLE. The 5-bit counter wraps to 0.
- **Stall.** While `axiir = 0`, `axiod`, `axiov` and `axiolast` hold stable.
- **Reset** (also mid-frame) sets: `axiov = 0`, `axiolast = 0`, `axiod = 0`, `err = 0`, `byte_cnt = 0`, state IDLE, `fi_ready = 1` on the first cycle after reset release. A partial frame is discarded, never resumed.

## Timing
- Field set accepted at edge T → byte 0 valid from T+1.
- With `axiir` held high: one byte per cycle, 32 cycles per frame.
- Last byte transferred at edge T' → IDLE at T'+1 (`fi_ready = 1`). The next field set can be accepted at T'+1, with its byte 0 at T'+2. Minimum frame period is 33 cycles.
- `axiolast = axiov && (byte_cnt == 31)`, registered alongside `axiod`.
- `err`, when enabled, pulses in the cycle after the rejected `fi_valid` handshake.

## Configuration
- `SIDE_INFO_FIELD_CHECK_EN` **defined:** on an IDLE handshake the field set is checked.
  - Illegal if any `[gr][ch]` has `wsf = 1` with `block_type == 0`, or `big_values > 288`.
  - An illegal set is consumed: `fi_ready` stays high, `err` pulses for 1 cycle, nothing is transmitted, state stays IDLE.
- `SIDE_INFO_FIELD_CHECK_EN` **undefined:** `err` is tied 0 and every field set is transmitted verbatim.

## Test plan
- **Single bit pattern.** All fields 0 except `main_data_begin = 9'h1FF`, `axiir = 1` → bytes 0xFF, 0x80, then 30×0x00. `axiolast` high only on byte 31. First byte one cycle after the handshake.
- **Window-switching branch.** gr0 ch0 with `wsf = 1`, `block_type = 2`, `mixed = 0`, `ts1 = 5'h1F`, `ts2 = 0`, `sbg = 7,0,7`, all other fields 0 → bytes 6..9 = 0x06, 0x7C, 0x1C, 0x70. All other bytes 0x00.
- **Backpressure.** `axiir` low for 3 cycles while byte 5 is presented → `axiod` and `axiov` stable through the stall. Exactly 32 transfers, byte order unchanged.
- **Back-to-back.** `fi_valid` held high with two distinct field sets → second accepted the cycle after the byte-31 transfer. 33-cycle period, no dropped or duplicated bytes.
- **Reset mid-frame.** `rst` low at byte 10 → `axiov = 0` after that edge. The next frame restarts at byte 0 with correct contents.
- **Field check** (`SIDE_INFO_FIELD_CHECK_EN` defined). `wsf = 1`/`block_type = 0`, or `big_values = 289` → one `err` pulse and no `axiov`. A legal set accepted next cycle transmits normally.
